// File: rtl/pkg_write_controller_pkg.sv
// Shared definitions for the linked-page packet buffer.
// Holds the write-controller FSM encoding, link-word field positions,
// page-size derivation and the link-word pack helper used by both the
// write and read sides.
package pkg_write_controller_pkg;

  typedef logic [2:0] wc_state_t;

  localparam wc_state_t S_IDLE   = 3'd0;
  localparam wc_state_t S_DATA   = 3'd1;
  localparam wc_state_t S_ALLOC  = 3'd2;
  localparam wc_state_t S_LINK   = 3'd3;
  localparam wc_state_t S_COMMIT = 3'd4;

  localparam int unsigned LINK_MAXW     = 64;
  localparam int unsigned LINK_NEXT_LSB = 0;

  function automatic int unsigned link_eop_bit(input int unsigned dw);
    return dw - 1;
  endfunction

  function automatic int unsigned link_count_lsb(input int unsigned pn);
    return pn;
  endfunction

  function automatic int unsigned page_words(input int unsigned aw, input int unsigned pn);
    return 32'd1 << (aw - pn);
  endfunction

  // Offset 0 of every page is the link word, the rest is payload.
  function automatic int unsigned payload_words(input int unsigned aw, input int unsigned pn);
    return page_words(aw, pn) - 1;
  endfunction

  // Returns a LINK_MAXW-wide word; callers size-cast to DATA_WIDTH.
  function automatic logic [LINK_MAXW-1:0] link_pack(
    input int unsigned          dw,
    input int unsigned          aw,
    input int unsigned          pn,
    input logic                 eop,
    input logic [LINK_MAXW-1:0] count,
    input logic [LINK_MAXW-1:0] nxt
  );
    logic [LINK_MAXW-1:0] w;
    logic [LINK_MAXW-1:0] nmask;
    logic [LINK_MAXW-1:0] cmask;
    nmask = (64'd1 << pn) - 64'd1;
    cmask = (64'd1 << (aw - pn)) - 64'd1;
    w = ((nxt & nmask) << LINK_NEXT_LSB) | ((count & cmask) << link_count_lsb(pn));
    if (eop) begin
      w = w | (64'd1 << link_eop_bit(dw));
    end
    return w;
  endfunction

endpackage

// File: rtl/pkg_write_controller.sv
// Upstream write stage of the linked-page packet buffer.
// Accepts a valid/ready word stream, pops pages from the free table,
// writes payload and link words into the packet RAM and pushes the
// head page of each completed packet into the data table.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready/in_data/in_last   input packet stream
//   free_table_read_req/_addr/_empty    free-page table pop interface
//   data_table_write_req/_addr          completed-packet push
//   ram_write_req/_addr/_data           packet RAM write port
//   busy                        controller not idle
import pkg_write_controller_pkg::*;

module pkg_write_controller #(
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned ADDR_PAGE_NUM_LOG = 4,
  parameter int unsigned DATA_WIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_last,
  output logic                         free_table_read_req,
  input  logic [ADDR_PAGE_NUM_LOG-1:0] free_table_read_addr,
  input  logic                         free_table_empty,
  output logic                         data_table_write_req,
  output logic [ADDR_PAGE_NUM_LOG-1:0] data_table_write_addr,
  output logic                         ram_write_req,
  output logic [ADDR_WIDTH-1:0]        ram_write_addr,
  output logic [DATA_WIDTH-1:0]        ram_write_data,
  output logic                         busy
);

  localparam int unsigned OFFW = ADDR_WIDTH - ADDR_PAGE_NUM_LOG;
  localparam int unsigned P    = payload_words(ADDR_WIDTH, ADDR_PAGE_NUM_LOG);
  localparam logic [OFFW-1:0] OFF_LAST = OFFW'(P);
  localparam logic [OFFW-1:0] OFF_FIRST = OFFW'(1);

  wc_state_t                    state_q, state_d;
  logic [ADDR_PAGE_NUM_LOG-1:0] cur_page_q, cur_page_d;
  logic [ADDR_PAGE_NUM_LOG-1:0] head_page_q, head_page_d;
  logic [OFFW-1:0]              offset_q, offset_d;
  logic [OFFW-1:0]              count_w;

  always_comb begin
    state_d     = state_q;
    cur_page_d  = cur_page_q;
    head_page_d = head_page_q;
    offset_d    = offset_q;
    // offset wraps to 0 after a full page, so offset-1 yields P there.
    count_w     = offset_q - OFF_FIRST;

    in_ready              = 1'b0;
    free_table_read_req   = 1'b0;
    data_table_write_req  = 1'b0;
    data_table_write_addr = '0;
    ram_write_req         = 1'b0;
    ram_write_addr        = '0;
    ram_write_data        = '0;

    unique case (state_q)
      S_IDLE: begin
        // rst_n qualifies the pop so nothing leaks out while reset is held.
        if (rst_n && in_valid && !free_table_empty) begin
          free_table_read_req = 1'b1;
          cur_page_d          = free_table_read_addr;
          head_page_d         = free_table_read_addr;
          offset_d            = OFF_FIRST;
          state_d             = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_write_req  = 1'b1;
          ram_write_addr = {cur_page_q, offset_q};
          ram_write_data = in_data;
          offset_d       = offset_q + OFF_FIRST;
          if (in_last) begin
            state_d = S_LINK;
          end else if (offset_q == OFF_LAST) begin
            state_d = S_ALLOC;
          end
        end
      end
      S_ALLOC: begin
        if (!free_table_empty) begin
          free_table_read_req = 1'b1;
          ram_write_req       = 1'b1;
          ram_write_addr      = {cur_page_q, {OFFW{1'b0}}};
          ram_write_data      = DATA_WIDTH'(link_pack(DATA_WIDTH, ADDR_WIDTH, ADDR_PAGE_NUM_LOG,
                                                      1'b0, '0, 64'(free_table_read_addr)));
          cur_page_d          = free_table_read_addr;
          offset_d            = OFF_FIRST;
          state_d             = S_DATA;
        end
      end
      S_LINK: begin
        ram_write_req  = 1'b1;
        ram_write_addr = {cur_page_q, {OFFW{1'b0}}};
        ram_write_data = DATA_WIDTH'(link_pack(DATA_WIDTH, ADDR_WIDTH, ADDR_PAGE_NUM_LOG,
                                               1'b1, 64'(count_w), 64'(cur_page_q)));
        state_d        = S_COMMIT;
      end
      S_COMMIT: begin
        data_table_write_req  = 1'b1;
        data_table_write_addr = head_page_q;
        state_d               = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_page_q  <= '0;
      head_page_q <= '0;
      offset_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_page_q  <= cur_page_d;
      head_page_q <= head_page_d;
      offset_q    <= offset_d;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_pkg_write_controller.sv
module tb_pkg_write_controller;

  localparam int P = 15;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        free_table_read_req;
  logic [3:0]  free_table_read_addr;
  logic        free_table_empty;
  logic        data_table_write_req;
  logic [3:0]  data_table_write_addr;
  logic        ram_write_req;
  logic [7:0]  ram_write_addr;
  logic [15:0] ram_write_data;
  logic        busy;

  pkg_write_controller #(
    .ADDR_WIDTH       (8),
    .ADDR_PAGE_NUM_LOG(4),
    .DATA_WIDTH       (16)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_data              (in_data),
    .in_last              (in_last),
    .free_table_read_req  (free_table_read_req),
    .free_table_read_addr (free_table_read_addr),
    .free_table_empty     (free_table_empty),
    .data_table_write_req (data_table_write_req),
    .data_table_write_addr(data_table_write_addr),
    .ram_write_req        (ram_write_req),
    .ram_write_addr       (ram_write_addr),
    .ram_write_data       (ram_write_data),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [3:0]  free_q[$];
  logic [23:0] wlog[$];
  logic [3:0]  popped[$];
  int          commits;
  logic [3:0]  commit_addr;

  typedef struct {
    int          n;
    int          stall;
    logic [3:0]  pg0;
    logic [3:0]  pg1;
    logic [7:0]  link_addr;
    logic [15:0] link_data;
    int          cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {in_ready, free_table_read_req, data_table_write_req, ram_write_req, busy,
            ram_write_addr, ram_write_data, data_table_write_addr};
  endfunction

  task automatic run_packet(input int n, input int stall, input bit gaps, input bit rel_rst,
                            input int abort_after, output int cycles);
    logic [15:0] words[$];
    logic [23:0] exp[$];
    int idx, stall_left, zero_viol, stall_viol, k, cnt;
    bit started, done, aborted, force_e;
    words = {};
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    wlog = {}; popped = {}; commits = 0; commit_addr = '0;
    idx = 0; stall_left = 0; zero_viol = 0; stall_viol = 0;
    started = 0; done = 0; aborted = 0; cycles = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      force_e              = (stall_left > 0);
      free_table_empty     = (free_q.size() == 0) || force_e;
      free_table_read_addr = (free_q.size() != 0) ? free_q[0] : 4'h0;
      in_valid             = (idx < n) && !(gaps && $urandom_range(0, 3) == 0);
      in_data              = (idx < n) ? words[idx] : 16'($urandom);
      in_last              = (idx == n - 1);
      if (rel_rst && c == 0) rst_n = 1'b1;
      if (abort_after > 0 && idx == abort_after) begin
        rst_n = 1'b0; in_valid = 1'b0; aborted = 1;
      end
      if (in_valid) started = 1;
      #3;
      if (started) cycles++;
      if (rel_rst && c == 0) check("first_pop_after_reset", free_table_read_req, 1);
      if (aborted) begin
        check("reset_abort_outputs_zero", all_outs(), 0);
        done = 1;
      end else begin
        if (force_e) begin
          if (in_ready || ram_write_req || free_table_read_req) stall_viol++;
          stall_left--;
        end
        if (!ram_write_req && (ram_write_addr != 0 || ram_write_data != 0)) zero_viol++;
        if (!data_table_write_req && data_table_write_addr != 0) zero_viol++;
        if (free_table_read_req) begin
          if (free_table_empty) zero_viol++;
          else popped.push_back(free_q.pop_front());
        end
        if (ram_write_req) wlog.push_back({ram_write_addr, ram_write_data});
        if (in_valid && in_ready) begin
          if ((idx + 1) % P == 0 && idx != n - 1) stall_left = stall;
          idx++;
        end
        if (data_table_write_req) begin
          commits++; commit_addr = data_table_write_addr; done = 1;
        end
      end
    end
    check("packet_completed", done, 1);

    // Reference: words fill pages P at a time; each non-final page ends in a
    // link to the next popped page, the final page links to itself with EOP.
    k = aborted ? 1 : (n + P - 1) / P;
    exp = {};
    check("pop_count", popped.size(), k);
    if (popped.size() == k) begin
      if (aborted) begin
        for (int w = 0; w < abort_after; w++) exp.push_back({popped[0], 4'(w + 1), words[w]});
      end else begin
        for (int pg = 0; pg < k; pg++) begin
          for (int w = pg * P; w < n && w < (pg + 1) * P; w++)
            exp.push_back({popped[pg], 4'(w - pg * P + 1), words[w]});
          if (pg < k - 1) exp.push_back({popped[pg], 4'h0, 16'(popped[pg + 1])});
          else begin
            cnt = n - pg * P;
            exp.push_back({popped[pg], 4'h0, 16'h8000 | 16'(cnt << 4) | 16'(popped[pg])});
          end
        end
      end
    end
    check("ram_write_count", wlog.size(), exp.size());
    for (int i = 0; i < wlog.size() && i < exp.size(); i++) check("ram_write", wlog[i], exp[i]);
    if (aborted) check("abort_no_commit", commits, 0);
    else begin
      check("commit_count", commits, 1);
      if (popped.size() > 0) check("commit_addr", commit_addr, popped[0]);
      if (!gaps) check("packet_cycles", cycles, 3 + n + (k - 1) * (1 + stall));
    end
    if (stall > 0 && k > 1) check("alloc_stall_quiet", stall_viol, 0);
    check("idle_outputs_zero", zero_viol, 0);

    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; rst_n = 1'b1;
    #3;
    check("post_packet_idle", all_outs(), 0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{3,  0, 4'h5, 4'h9, 8'h50, 16'h8035, 6};
    vecs[1] = '{15, 0, 4'h5, 4'h9, 8'h50, 16'h80F5, 18};
    vecs[2] = '{20, 0, 4'h5, 4'h9, 8'h90, 16'h8059, 24};
    vecs[3] = '{20, 4, 4'h5, 4'h9, 8'h90, 16'h8059, 28};
    vecs[4] = '{16, 0, 4'h2, 4'h7, 8'h70, 16'h8017, 20};
    vecs[5] = '{1,  0, 4'hC, 4'h3, 8'hC0, 16'h801C, 4};

    rst_n = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    free_table_empty = 1'b1; free_table_read_addr = '0;
    #2 rst_n = 1'b0;

    // Reset held with traffic pending: every output must stay quiet.
    free_q = {};
    free_q.push_back(vecs[0].pg0);
    free_q.push_back(vecs[0].pg1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 16'hABCD; in_last = 1'b0;
      free_table_empty = 1'b0; free_table_read_addr = free_q[0];
      #3;
      check("reset_outputs_zero", all_outs(), 0);
    end

    for (int i = 0; i < 6; i++) begin
      free_q = {};
      free_q.push_back(vecs[i].pg0);
      free_q.push_back(vecs[i].pg1);
      run_packet(vecs[i].n, vecs[i].stall, 0, i == 0, 0, cyc);
      check("vec_cycles", cyc, vecs[i].cycles);
      check("vec_commit_addr", commit_addr, vecs[i].pg0);
      if (wlog.size() > 0) check("vec_final_link", wlog[wlog.size() - 1], {vecs[i].link_addr, vecs[i].link_data});
    end

    // Empty free table at packet start: no accept, no pop, stay idle.
    free_q = {};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b0;
      free_table_empty = 1'b1; free_table_read_addr = 4'h6;
      #3;
      check("empty_start_hold", {in_ready, free_table_read_req, busy, ram_write_req}, 0);
    end

    // Reset after word 2 of a 10-word packet, then a clean packet on the next head.
    free_q = {};
    free_q.push_back(4'h5);
    free_q.push_back(4'h9);
    run_packet(10, 0, 0, 0, 2, cyc);
    run_packet(4, 0, 0, 0, 0, cyc);
    check("after_abort_commit_addr", commit_addr, 4'h9);
    check("after_abort_first_write", (wlog.size() > 0) ? wlog[0][23:16] : 8'hFF, 8'h91);

    for (int r = 0; r < 40; r++) begin
      int n, k;
      n = $urandom_range(1, 50);
      k = (n + P - 1) / P;
      free_q = {};
      for (int j = 0; j < k; j++) free_q.push_back(4'($urandom_range(0, 15)));
      run_packet(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
